// File: rtl/jitter_alarm_if.sv
// Bus between the jitter measurement/status side and jitter_alarm_manager.
interface jitter_alarm_if #(
   parameter int unsigned MEAS_W = 16,
   parameter int unsigned EVT_W  = 8
);
   logic              cfg_enable;
   logic              meas_valid;
   logic [MEAS_W-1:0] jitter_measure;
   logic              irq_ack;
   logic              peak_clr;
   logic              alarm;
   logic              irq;
   logic [1:0]        state;
   logic [MEAS_W-1:0] peak_jitter;
   logic [EVT_W-1:0]  event_count;

   modport master (
      output cfg_enable, meas_valid, jitter_measure, irq_ack, peak_clr,
      input  alarm, irq, state, peak_jitter, event_count
   );

   modport slave (
      input  cfg_enable, meas_valid, jitter_measure, irq_ack, peak_clr,
      output alarm, irq, state, peak_jitter, event_count
   );
endinterface

// File: rtl/jitter_alarm_manager.sv
// Qualified, debounced jitter alarm with hysteresis, peak hold, event count
// and sticky interrupt. MEAS_W/EVT_W must match the connected interface.
module jitter_alarm_manager #(
   parameter int unsigned MEAS_W        = 16,
   parameter int unsigned SET_THRESHOLD = 24,
   parameter int unsigned CLR_THRESHOLD = 16,
   parameter int unsigned SET_COUNT     = 4,
   parameter int unsigned CLR_COUNT     = 8,
   parameter int unsigned EVT_W         = 8
) (
   input  logic           clk,
   input  logic           rst,
   jitter_alarm_if.slave  bus
);
   localparam int unsigned RUN_MAX = (SET_COUNT > CLR_COUNT) ? SET_COUNT : CLR_COUNT;
   localparam int unsigned RUN_W   = $clog2(RUN_MAX) + 1;

   localparam logic [1:0] ST_NORMAL  = 2'd0;
   localparam logic [1:0] ST_PENDING = 2'd1;
   localparam logic [1:0] ST_ALARM   = 2'd2;
   localparam logic [1:0] ST_RECOVER = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic              alarm_q, alarm_d;
   logic              irq_q, irq_d;
   logic [EVT_W-1:0]  event_q, event_d;
   logic [MEAS_W-1:0] peak_q, peak_d;

   logic              qual_c;
   logic              high_c;
   logic              low_c;
   logic              entry_c;
   logic [RUN_W-1:0]  run_inc_c;

   // Sample classification and saturating run increment
   always_comb begin
      qual_c    = bus.meas_valid && bus.cfg_enable;
      high_c    = bus.jitter_measure > MEAS_W'(SET_THRESHOLD);
      low_c     = bus.jitter_measure < MEAS_W'(CLR_THRESHOLD);
      run_inc_c = (run_q == '1) ? run_q : run_q + RUN_W'(1);
   end

   // Next-state: qualification FSM, alarm, irq, event counter, peak hold
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      entry_c = 1'b0;
      irq_d   = irq_q;
      event_d = event_q;
      peak_d  = peak_q;

      if (!bus.cfg_enable) begin
         state_d = ST_NORMAL;
         run_d   = '0;
      end else if (bus.meas_valid) begin
         case (state_q)
            ST_NORMAL: begin
               if (high_c) begin
                  run_d = RUN_W'(1);
                  if (SET_COUNT == 1) begin
                     state_d = ST_ALARM;
                     entry_c = 1'b1;
                  end else begin
                     state_d = ST_PENDING;
                  end
               end
            end
            ST_PENDING: begin
               if (high_c) begin
                  if (run_inc_c == RUN_W'(SET_COUNT)) begin
                     state_d = ST_ALARM;
                     run_d   = '0;
                     entry_c = 1'b1;
                  end else begin
                     run_d = run_inc_c;
                  end
               end else begin
                  state_d = ST_NORMAL;
                  run_d   = '0;
               end
            end
            ST_ALARM: begin
               if (low_c) begin
                  run_d   = RUN_W'(1);
                  state_d = (CLR_COUNT == 1) ? ST_NORMAL : ST_RECOVER;
                  if (CLR_COUNT == 1) begin
                     run_d = '0;
                  end
               end else begin
                  run_d = '0;
               end
            end
            default: begin
               if (low_c) begin
                  if (run_inc_c == RUN_W'(CLR_COUNT)) begin
                     state_d = ST_NORMAL;
                     run_d   = '0;
                  end else begin
                     run_d = run_inc_c;
                  end
               end else begin
                  state_d = ST_ALARM;
                  run_d   = '0;
               end
            end
         endcase
      end

      alarm_d = (state_d == ST_ALARM) || (state_d == ST_RECOVER);

      // Set wins over acknowledge
      if (entry_c) begin
         irq_d = 1'b1;
      end else if (bus.irq_ack) begin
         irq_d = 1'b0;
      end

      if (entry_c && (event_q != '1)) begin
         event_d = event_q + EVT_W'(1);
      end

      if (bus.peak_clr) begin
         peak_d = qual_c ? bus.jitter_measure : '0;
      end else if (qual_c && (bus.jitter_measure > peak_q)) begin
         peak_d = bus.jitter_measure;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_NORMAL;
         run_q   <= '0;
         alarm_q <= 1'b0;
         irq_q   <= 1'b0;
         event_q <= '0;
         peak_q  <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         alarm_q <= alarm_d;
         irq_q   <= irq_d;
         event_q <= event_d;
         peak_q  <= peak_d;
      end
   end

   assign bus.state       = state_q;
   assign bus.alarm       = alarm_q;
   assign bus.irq         = irq_q;
   assign bus.event_count = event_q;
   assign bus.peak_jitter = peak_q;

endmodule

// File: tb/tb_jitter_alarm_manager.sv
// Directed bench for jitter_alarm_manager: default instance plus an EVT_W=2
// instance sharing the same stimulus for event-counter saturation.
module tb_jitter_alarm_manager;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   jitter_alarm_if #(.MEAS_W(16), .EVT_W(8)) bus_a ();
   jitter_alarm_if #(.MEAS_W(16), .EVT_W(2)) bus_b ();

   assign bus_b.cfg_enable     = bus_a.cfg_enable;
   assign bus_b.meas_valid     = bus_a.meas_valid;
   assign bus_b.jitter_measure = bus_a.jitter_measure;
   assign bus_b.irq_ack        = bus_a.irq_ack;
   assign bus_b.peak_clr       = bus_a.peak_clr;

   jitter_alarm_manager #(.MEAS_W(16), .EVT_W(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   jitter_alarm_manager #(.MEAS_W(16), .EVT_W(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [15:0] v);
      bus_a.meas_valid     = 1'b1;
      bus_a.jitter_measure = v;
      tick();
      bus_a.meas_valid     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus_a.cfg_enable     = 1'b1;
      bus_a.meas_valid     = 1'b0;
      bus_a.jitter_measure = '0;
      bus_a.irq_ack        = 1'b0;
      bus_a.peak_clr       = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({bus_a.alarm, bus_a.irq, bus_a.state, bus_a.peak_jitter, bus_a.event_count} !== 28'd0) begin
         errors++;
         $display("FAIL reset_a got alarm=%0b irq=%0b state=%0d peak=%0d evt=%0d exp all 0",
                  bus_a.alarm, bus_a.irq, bus_a.state, bus_a.peak_jitter, bus_a.event_count);
      end
      checks++;
      if ({bus_b.alarm, bus_b.irq, bus_b.state, bus_b.event_count} !== 6'd0) begin
         errors++;
         $display("FAIL reset_b got alarm=%0b irq=%0b state=%0d evt=%0d exp all 0",
                  bus_b.alarm, bus_b.irq, bus_b.state, bus_b.event_count);
      end
   endtask

   task automatic test_set_qualify();
      int exp_st [4];
      exp_st = '{1, 1, 1, 2};
      for (int i = 0; i < 4; i++) begin
         sample(16'd30);
         checks++;
         if (bus_a.state !== 2'(exp_st[i])) begin
            errors++;
            $display("FAIL set_state%0d got %0d exp %0d", i, bus_a.state, exp_st[i]);
         end
         if (i < 3) begin
            checks++;
            if (bus_a.alarm !== 1'b0) begin
               errors++;
               $display("FAIL set_early_alarm%0d got %0b exp 0", i, bus_a.alarm);
            end
         end
      end
      checks++;
      if ({bus_a.alarm, bus_a.irq, bus_a.event_count, bus_a.peak_jitter} !== {1'b1, 1'b1, 8'd1, 16'd30}) begin
         errors++;
         $display("FAIL set_entry got alarm=%0b irq=%0b evt=%0d peak=%0d exp 1 1 1 30",
                  bus_a.alarm, bus_a.irq, bus_a.event_count, bus_a.peak_jitter);
      end
   endtask

   task automatic test_recover();
      // four lows into RECOVER, then a mid-band sample bounces back to ALARM
      for (int i = 0; i < 4; i++) begin
         sample(16'd10);
         checks++;
         if ({bus_a.state, bus_a.alarm} !== {2'd3, 1'b1}) begin
            errors++;
            $display("FAIL rec_state%0d got state=%0d alarm=%0b exp 3 1", i, bus_a.state, bus_a.alarm);
         end
      end
      sample(16'd20);
      checks++;
      if ({bus_a.state, bus_a.alarm, bus_a.event_count} !== {2'd2, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL rec_bounce got state=%0d alarm=%0b evt=%0d exp 2 1 1",
                  bus_a.state, bus_a.alarm, bus_a.event_count);
      end
      for (int i = 0; i < 8; i++) begin
         sample(16'd10);
         checks++;
         if (i < 7) begin
            if ({bus_a.state, bus_a.alarm} !== {2'd3, 1'b1}) begin
               errors++;
               $display("FAIL rec_run%0d got state=%0d alarm=%0b exp 3 1", i, bus_a.state, bus_a.alarm);
            end
         end else begin
            if ({bus_a.state, bus_a.alarm, bus_a.event_count, bus_a.irq} !== {2'd0, 1'b0, 8'd1, 1'b1}) begin
               errors++;
               $display("FAIL rec_release got state=%0d alarm=%0b evt=%0d irq=%0b exp 0 0 1 1",
                        bus_a.state, bus_a.alarm, bus_a.event_count, bus_a.irq);
            end
         end
      end
   endtask

   task automatic test_irq_ack();
      bus_a.irq_ack = 1'b1;
      tick();
      bus_a.irq_ack = 1'b0;
      checks++;
      if (bus_a.irq !== 1'b0) begin
         errors++;
         $display("FAIL ack_clear got %0b exp 0", bus_a.irq);
      end
      for (int i = 0; i < 3; i++) sample(16'd30);
      bus_a.irq_ack = 1'b1;
      sample(16'd30);
      checks++;
      if ({bus_a.state, bus_a.irq, bus_a.event_count} !== {2'd2, 1'b1, 8'd2}) begin
         errors++;
         $display("FAIL ack_set_wins got state=%0d irq=%0b evt=%0d exp 2 1 2",
                  bus_a.state, bus_a.irq, bus_a.event_count);
      end
      tick();
      bus_a.irq_ack = 1'b0;
      checks++;
      if (bus_a.irq !== 1'b0) begin
         errors++;
         $display("FAIL ack_later got %0b exp 0", bus_a.irq);
      end
   endtask

   task automatic test_mid_band();
      int exp_st [5];
      logic [15:0] vals [5];
      exp_st = '{1, 1, 1, 0, 1};
      vals   = '{16'd30, 16'd30, 16'd30, 16'd20, 16'd30};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         sample(vals[i]);
         checks++;
         if (bus_a.state !== 2'(exp_st[i])) begin
            errors++;
            $display("FAIL mid_state%0d got %0d exp %0d", i, bus_a.state, exp_st[i]);
         end
      end
      checks++;
      if ({bus_a.alarm, bus_a.event_count} !== {1'b0, 8'd0}) begin
         errors++;
         $display("FAIL mid_noalarm got alarm=%0b evt=%0d exp 0 0", bus_a.alarm, bus_a.event_count);
      end
   endtask

   task automatic test_gap();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         sample(16'd30);
         tick();
         if (i < 3) begin
            checks++;
            if (bus_a.state !== 2'd1) begin
               errors++;
               $display("FAIL gap_hold%0d got %0d exp 1", i, bus_a.state);
            end
         end
      end
      checks++;
      if ({bus_a.state, bus_a.alarm} !== {2'd2, 1'b1}) begin
         errors++;
         $display("FAIL gap_alarm got state=%0d alarm=%0b exp 2 1", bus_a.state, bus_a.alarm);
      end
   endtask

   task automatic test_peak();
      logic [15:0] vals [3];
      logic [15:0] exp_pk [3];
      vals   = '{16'd5, 16'd40, 16'd12};
      exp_pk = '{16'd5, 16'd40, 16'd40};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         sample(vals[i]);
         checks++;
         if (bus_a.peak_jitter !== exp_pk[i]) begin
            errors++;
            $display("FAIL peak_%0d got %0d exp %0d", i, bus_a.peak_jitter, exp_pk[i]);
         end
      end
      bus_a.peak_clr = 1'b1;
      sample(16'd7);
      checks++;
      if (bus_a.peak_jitter !== 16'd7) begin
         errors++;
         $display("FAIL peak_clr_sample got %0d exp 7", bus_a.peak_jitter);
      end
      tick();
      bus_a.peak_clr = 1'b0;
      checks++;
      if (bus_a.peak_jitter !== 16'd0) begin
         errors++;
         $display("FAIL peak_clr_only got %0d exp 0", bus_a.peak_jitter);
      end
   endtask

   task automatic test_enable();
      do_reset();
      sample(16'd30);
      sample(16'd30);
      bus_a.cfg_enable = 1'b0;
      sample(16'd50);
      checks++;
      if ({bus_a.state, bus_a.alarm, bus_a.peak_jitter, bus_a.event_count} !== {2'd0, 1'b0, 16'd30, 8'd0}) begin
         errors++;
         $display("FAIL en_pending got state=%0d alarm=%0b peak=%0d evt=%0d exp 0 0 30 0",
                  bus_a.state, bus_a.alarm, bus_a.peak_jitter, bus_a.event_count);
      end
      bus_a.cfg_enable = 1'b1;
      for (int i = 0; i < 4; i++) sample(16'd30);
      checks++;
      if ({bus_a.state, bus_a.alarm} !== {2'd2, 1'b1}) begin
         errors++;
         $display("FAIL en_rearm got state=%0d alarm=%0b exp 2 1", bus_a.state, bus_a.alarm);
      end
      bus_a.cfg_enable = 1'b0;
      tick();
      checks++;
      if ({bus_a.state, bus_a.alarm, bus_a.irq, bus_a.event_count} !== {2'd0, 1'b0, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL en_alarm_off got state=%0d alarm=%0b irq=%0b evt=%0d exp 0 0 1 1",
                  bus_a.state, bus_a.alarm, bus_a.irq, bus_a.event_count);
      end
      bus_a.cfg_enable = 1'b1;
      sample(16'd30);
      checks++;
      if (bus_a.state !== 2'd1) begin
         errors++;
         $display("FAIL en_restart got %0d exp 1", bus_a.state);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         for (int i = 0; i < 4; i++) sample(16'd30);
         checks++;
         if ({bus_b.event_count, bus_a.event_count} !== {2'((k > 3) ? 3 : k), 8'(k)}) begin
            errors++;
            $display("FAIL sat_entry%0d got b=%0d a=%0d exp b=%0d a=%0d",
                     k, bus_b.event_count, bus_a.event_count, (k > 3) ? 3 : k, k);
         end
         for (int i = 0; i < 8; i++) sample(16'd10);
      end
      sample(16'd30);
      sample(16'd30);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({bus_a.alarm, bus_a.irq, bus_a.state, bus_a.peak_jitter, bus_a.event_count,
           bus_b.event_count, bus_b.state} !== 32'd0) begin
         errors++;
         $display("FAIL sat_reset got a: alarm=%0b irq=%0b state=%0d peak=%0d evt=%0d b: evt=%0d state=%0d exp all 0",
                  bus_a.alarm, bus_a.irq, bus_a.state, bus_a.peak_jitter, bus_a.event_count,
                  bus_b.event_count, bus_b.state);
      end
      for (int i = 0; i < 3; i++) sample(16'd30);
      checks++;
      if (bus_a.state !== 2'd1) begin
         errors++;
         $display("FAIL sat_run_discard got %0d exp 1", bus_a.state);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      test_reset();
      test_set_qualify();
      test_recover();
      test_irq_ack();
      test_mid_band();
      test_gap();
      test_peak();
      test_enable();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
